// File: rtl/dpwm_duty_sched.sv
// dpwm_duty_sched: clamps compensator duty commands, soft-starts and fault-gates them, and hands them to the DPWM only at period boundaries
module dpwm_duty_sched #(
  parameter int DW      = 9,
  parameter int CNT_W   = 6,
  parameter int DMAX    = 460,
  parameter int DMIN    = 0,
  parameter int SS_STEP = 4,
  parameter int SS_DIV  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fault,
  input  logic [DW-1:0] d_cmd,
  input  logic          d_cmd_vld,
  output logic          d_cmd_rdy,
  output logic [DW-1:0] d_n_out,
  output logic          pwm_en,
  output logic          period_tick,
  output logic [1:0]    state
);
  typedef enum logic [1:0] {IDLE, SOFTSTART, RUN, FLT} state_t;
  localparam logic [DW-1:0] DMAX_W = DW'(DMAX);
  localparam logic [DW-1:0] DMIN_W = DW'(DMIN);
  localparam int SW = SS_DIV > 1 ? $clog2(SS_DIV) : 1;
  localparam logic [SW-1:0] SS_LAST = SW'(SS_DIV - 1);
  state_t st, st_n;
  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [DW-1:0] shadow, shadow_n, ramp, ramp_n, d_n, clamped, sh_eff, ramp_sat;
  logic [DW:0] ramp_sum;
  logic [SW-1:0] ss_cnt, ss_n;
  logic pen_n, cap, last;
  assign state = st;
  assign d_cmd_rdy = (st == SOFTSTART) || (st == RUN);
  assign pcnt_n = pcnt + 1'b1;
  assign cap = d_cmd_vld && d_cmd_rdy && !fault;
  assign clamped = d_cmd > DMAX_W ? DMAX_W : (d_cmd <= DMIN_W ? DMIN_W : d_cmd);
  // a command captured in the boundary cycle is forwarded straight into that boundary's update
  assign sh_eff = cap ? clamped : shadow;
  assign ramp_sum = {1'b0, ramp} + (DW + 1)'(SS_STEP);
  assign ramp_sat = ramp_sum > {1'b0, DMAX_W} ? DMAX_W : ramp_sum[DW-1:0];
  assign last = ss_cnt == SS_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st          <= IDLE;
      pcnt        <= '0;
      period_tick <= 1'b0;
      d_n_out     <= '0;
      pwm_en      <= 1'b0;
      shadow      <= '0;
      ramp        <= '0;
      ss_cnt      <= '0;
    end else begin
      st          <= st_n;
      pcnt        <= pcnt_n;
      period_tick <= &pcnt_n;
      d_n_out     <= d_n;
      pwm_en      <= pen_n;
      shadow      <= shadow_n;
      ramp        <= ramp_n;
      ss_cnt      <= ss_n;
    end
  always_comb begin
    st_n     = st;
    d_n      = d_n_out;
    pen_n    = pwm_en;
    shadow_n = sh_eff;
    ramp_n   = ramp;
    ss_n     = ss_cnt;
    if (fault && st != FLT) begin
      st_n  = FLT;
      pen_n = 1'b0;
      d_n   = '0;
    end else if (st == FLT) begin
      if (!en && !fault) begin
        st_n     = IDLE;
        shadow_n = '0;
      end
    end else if (st == IDLE) begin
      if (en && period_tick) begin
        st_n   = SOFTSTART;
        ramp_n = '0;
        ss_n   = '0;
        pen_n  = 1'b1;
      end
    end else if (!en) begin
      st_n   = IDLE;
      pen_n  = 1'b0;
      d_n    = '0;
      ramp_n = '0;
    end else if (period_tick) begin
      if (st == RUN) d_n = sh_eff;
      else begin
        d_n    = sh_eff < ramp ? sh_eff : ramp;
        ss_n   = last ? '0 : ss_cnt + 1'b1;
        ramp_n = last ? ramp_sat : ramp;
        st_n   = ramp == DMAX_W ? RUN : SOFTSTART;
      end
    end
  end
endmodule

// File: tb/tb_dpwm_duty_sched.sv
// tb_dpwm_duty_sched: directed vectors and hand-written sequences for the duty scheduler
module tb_dpwm_duty_sched;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, fault = 1'b0, d_cmd_vld = 1'b0;
  logic [8:0] d_cmd = '0;
  logic d_cmd_rdy, pwm_en, period_tick, d_cmd_rdy2, pwm_en2, period_tick2;
  logic [8:0] d_n_out, d_n_out2;
  logic [1:0] state, state2;
  int total = 0, bad = 0, pc = 0;
  typedef struct {logic [8:0] cmd; logic [8:0] e1; logic [8:0] e2;} vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  dpwm_duty_sched dut (.clk(clk), .rst(rst), .en(en), .fault(fault), .d_cmd(d_cmd),
    .d_cmd_vld(d_cmd_vld), .d_cmd_rdy(d_cmd_rdy), .d_n_out(d_n_out), .pwm_en(pwm_en),
    .period_tick(period_tick), .state(state));
  dpwm_duty_sched #(.DMIN(20)) dut2 (.clk(clk), .rst(rst), .en(en), .fault(fault), .d_cmd(d_cmd),
    .d_cmd_vld(d_cmd_vld), .d_cmd_rdy(d_cmd_rdy2), .d_n_out(d_n_out2), .pwm_en(pwm_en2),
    .period_tick(period_tick2), .state(state2));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pc = (pc + 1) % 64;
  endtask

  task automatic goto(input int p);
    for (int i = 0; i < 70 && pc != p; i++) step();
  endtask

  task automatic boundary();
    goto(63);
    step();
  endtask

  task automatic cmd1(input logic [8:0] c);
    d_cmd = c;
    d_cmd_vld = 1'b1;
    step();
    d_cmd_vld = 1'b0;
  endtask

  task automatic count_to_tick(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (period_tick) begin
        n = i;
        break;
      end
    end
    chk(name, n, 63);
  endtask

  initial begin
    int ramp_m, ss_m, exp_dn, exp_st, nb, prev;
    tbl[0] = '{9'd200, 9'd200, 9'd200};
    tbl[1] = '{9'd511, 9'd460, 9'd460};
    tbl[2] = '{9'd460, 9'd460, 9'd460};
    tbl[3] = '{9'd461, 9'd460, 9'd460};
    tbl[4] = '{9'd0,   9'd0,   9'd20};
    tbl[5] = '{9'd5,   9'd5,   9'd20};
    tbl[6] = '{9'd100, 9'd100, 9'd100};
    tbl[7] = '{9'd300, 9'd300, 9'd300};
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_dn", d_n_out, 0);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_rdy", d_cmd_rdy, 0);
    rst = 1'b0;
    pc = 0;
    en = 1'b1;
    d_cmd = 9'd200;
    d_cmd_vld = 1'b1;
    count_to_tick("first_tick");
    chk("idle_at_tick", state, 0);
    step();
    chk("ss_entry_state", state, 1);
    chk("ss_entry_pwm_en", pwm_en, 1);
    chk("ss_entry_rdy", d_cmd_rdy, 1);
    chk("ss_entry_dn", d_n_out, 0);
    ramp_m = 0;
    ss_m = 0;
    nb = 0;
    prev = 0;
    exp_st = 1;
    while (exp_st != 2 && nb < 300) begin
      goto(63);
      chk("ss_hold_mid_period", d_n_out, prev);
      step();
      nb++;
      exp_dn = ramp_m < 200 ? ramp_m : 200;
      exp_st = ramp_m == 460 ? 2 : 1;
      chk("ss_dn", d_n_out, exp_dn);
      chk("ss_dn_dmin20", d_n_out2, exp_dn);
      chk("ss_state", state, exp_st);
      if (ss_m == 1) begin
        ss_m = 0;
        ramp_m = ramp_m + 4 > 460 ? 460 : ramp_m + 4;
      end else ss_m++;
      prev = exp_dn;
    end
    chk("boundaries_to_run", nb, 231);
    d_cmd_vld = 1'b0;
    goto(10);
    cmd1(9'd100);
    goto(30);
    cmd1(9'd300);
    goto(63);
    chk("run_hold_before_boundary", d_n_out, 200);
    cmd1(9'd50);
    chk("run_bypass_dn", d_n_out, 50);
    chk("run_bypass_dn2", d_n_out2, 50);
    prev = 50;
    for (int i = 0; i < 8; i++) begin
      goto(20);
      cmd1(tbl[i].cmd);
      goto(63);
      chk("tbl_hold", d_n_out, prev);
      step();
      chk("tbl_dn", d_n_out, tbl[i].e1);
      chk("tbl_dn_dmin20", d_n_out2, tbl[i].e2);
      prev = tbl[i].e1;
    end
    goto(17);
    fault = 1'b1;
    step();
    fault = 1'b0;
    chk("fault_state", state, 3);
    chk("fault_pwm_en", pwm_en, 0);
    chk("fault_dn", d_n_out, 0);
    chk("fault_rdy", d_cmd_rdy, 0);
    repeat (70) step();
    chk("fault_latched", state, 3);
    chk("fault_latched_pwm_en", pwm_en, 0);
    en = 1'b0;
    step();
    chk("fault_exit_idle", state, 0);
    en = 1'b1;
    boundary();
    chk("resoft_state", state, 1);
    boundary();
    boundary();
    boundary();
    chk("shadow_cleared_dn", d_n_out, 0);
    cmd1(9'd200);
    boundary();
    chk("resoft_b4_dn", d_n_out, 4);
    boundary();
    chk("resoft_b5_dn", d_n_out, 8);
    fault = 1'b1;
    en = 1'b0;
    step();
    chk("fault_over_en_state", state, 3);
    fault = 1'b0;
    step();
    chk("fault_en_low_exit", state, 0);
    en = 1'b1;
    boundary();
    chk("ss2_state", state, 1);
    boundary();
    cmd1(9'd200);
    boundary();
    boundary();
    chk("ss2_b3_dn", d_n_out, 4);
    goto(30);
    en = 1'b0;
    step();
    chk("disable_state", state, 0);
    chk("disable_dn", d_n_out, 0);
    chk("disable_pwm_en", pwm_en, 0);
    en = 1'b1;
    boundary();
    boundary();
    boundary();
    boundary();
    chk("ss3_b3_dn_shadow_kept", d_n_out, 4);
    chk("ss3_pwm_en", pwm_en, 1);
    goto(40);
    rst = 1'b1;
    #1;
    chk("async_rst_pwm_en", pwm_en, 0);
    chk("async_rst_dn", d_n_out, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_pwm_en2", pwm_en2, 0);
    step();
    rst = 1'b0;
    pc = 0;
    count_to_tick("tick_after_rst");
    chk("idle_after_rst", state, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpwm_duty_sched.md
Name: dpwm_duty_sched

Overview:
- Duty-command scheduler and supervisor for the hybrid (counter + delay-line) DPWM of the digital buck converter.
- Accepts duty words from the compensator and clamps them to safe limits.
- Applies a soft-start ramp after enable and shuts the PWM down on fault.
- Delivers the 9-bit duty word to the DPWM only at switching-period boundaries, so the DPWM never sees a mid-period change.

Parameters:
- DW, 9: duty word width. Upper CNT_W bits drive the counter compare; the lower DW-CNT_W bits drive the delay-line select.
- CNT_W, 6: period counter width. Switching period = 2^CNT_W clk cycles.
- DMAX, 460: maximum duty code allowed at the output.
- DMIN, 0: minimum duty code in RUN.
- SS_STEP, 4: ramp-limit increment per soft-start step.
- SS_DIV, 2: switching periods per soft-start step (must be >= 1).

Ports:
- clk, in, 1: system clock. Same clock as the DPWM.
- rst, in, 1: reset. Asynchronous, active-high.
- en, in, 1: converter enable, level-sensitive.
- fault, in, 1: overcurrent/overvoltage fault, synchronous to clk, level-sensitive.
- d_cmd, in, DW: duty command from the compensator.
- d_cmd_vld, in, 1: d_cmd valid.
- d_cmd_rdy, out, 1: scheduler accepting commands.
- d_n_out, out, DW: duty word to the DPWM d_n_input.
- pwm_en, out, 1: DPWM output gate. The DPWM duty must be ANDed with this.
- period_tick, out, 1: one-cycle pulse on the last clk of each period (pcnt == 2^CNT_W-1).
- state, out, 2: 0 IDLE, 1 SOFTSTART, 2 RUN, 3 FAULT.

Behaviour:
- Reset values: pcnt=0, state=IDLE, d_n_out=0, pwm_en=0, period_tick=0, d_cmd_rdy=0, shadow=0, ramp=0, ss_cnt=0.
- Period counter:
  - pcnt free-runs 0..2^CNT_W-1 and wraps to 0. Counts in every state.
  - It is released from reset in the same cycle as the DPWM counter, so phases are aligned.
  - period_tick is registered and is high while pcnt == 2^CNT_W-1.
- d_n_out timing: d_n_out is only updated on the clk edge ending a period_tick cycle. The new value is therefore stable when the DPWM counter is 0. The fault and disable paths below are the only exceptions.
- Command capture:
  - d_cmd_rdy = 1 in SOFTSTART and RUN, otherwise 0.
  - On vld&rdy, shadow <= clamp(d_cmd, DMIN, DMAX).
  - Latest command wins; there is no queue.
  - A capture in a period_tick cycle is used at that same boundary: the bypass value feeds the update.
- IDLE:
  - d_n_out=0, pwm_en=0.
  - If en=1, fault=0 and period_tick: go to SOFTSTART, ramp<=0, ss_cnt<=0, pwm_en<=1.
- SOFTSTART:
  - At each period_tick, ss_cnt increments.
  - When ss_cnt reaches SS_DIV-1: ss_cnt<=0 and ramp<=min(ramp+SS_STEP, DMAX). The sum is computed at DW+1 bits and saturates, never wraps.
  - d_n_out <= min(shadow, ramp) at every boundary, using the pre-increment ramp.
  - When ramp == DMAX at a boundary, go to RUN.
- RUN: at each period_tick, d_n_out <= shadow.
- Disable:
  - en=0 in SOFTSTART or RUN: next clk state=IDLE, pwm_en=0, d_n_out=0, ramp=0.
  - This is immediate and does not wait for a boundary.
  - Shadow is retained.
- Fault:
  - fault=1 in any state other than FAULT: next clk state=FAULT, pwm_en=0, d_n_out=0, d_cmd_rdy=0. Immediate.
  - Fault has priority over en and over command capture in the same cycle.
- FAULT:
  - Latched. Stays in FAULT while en=1 even after fault clears.
  - Exit to IDLE only when en=0 and fault=0. Shadow is cleared on exit.
- Re-enable after IDLE always re-runs the full soft-start; there is no bypass.
- Async rst mid-operation: all outputs go to reset values immediately; pwm_en drops without waiting for clk.

Test Plan:
- Reset then en=1, d_cmd=200 valid: state goes IDLE→SOFTSTART at the first period_tick. d_n_out follows ramp 0,0,4,4,8,… (SS_STEP=4, SS_DIV=2), changing only on period_tick edges, then holds at 200. RUN is entered once ramp hits 460, after 115 steps / 230 periods.
- In RUN, d_cmd=100 then 300 mid-period, then 50 in the period_tick cycle: d_n_out changes once, at the boundary, to 50.
- Clamp: d_cmd=511 in RUN → d_n_out=460 at the next boundary. With DMIN=20, d_cmd=5 → 20.
- Fault pulse of one cycle at pcnt=17 in RUN: next clk pwm_en=0, d_n_out=0, state=3. Stays in FAULT after fault clears with en=1. en=0 → IDLE; en=1 → fresh soft-start from 0.
- fault and en falling in the same cycle → FAULT, not IDLE. en=0 alone at pcnt=30 in SOFTSTART → IDLE next clk with d_n_out=0.
- rst asserted mid-RUN between clk edges: pwm_en, d_n_out and state go to 0 asynchronously. After release, pcnt restarts at 0 and period_tick first fires at pcnt=63.
